// File: rtl/vram_display_reader.sv
// vram_display_reader
//
// Scans a 1-bit-per-pixel VRAM in raster order and produces VGA timing
// together with RGB444 pixel colours. Every state change is gated by
// pixel_tick_i. One read address is issued per active pixel. The VRAM
// returns its data one clk after the address. Ticks are always at least two
// clks apart, so the data for the current address is valid at the next tick.
//
// Ports
//   clk_i              system clock (single domain)
//   reset_i            synchronous, active-high reset
//   pixel_tick_i       one-clk pixel enable, never on two consecutive clks
//   vram_rd_data_i     VRAM read data (bit 0 is the cell value)
//   vram_rd_address_o  VRAM read address (raster index of the current pixel)
//   hsync_o, vsync_o   active-low sync pulses
//   rgb_o              RGB444 pixel colour
//   video_on_o         high while rgb_o shows an active pixel
//   vblank_o           high while the displayed line is below the active area
//   frame_start_o      one-clk pulse after the tick that wraps the frame
//
// Handshake: there is none. pixel_tick_i is a qualifier. The outputs are
// registered on a tick from the pre-tick counters, so they lag the counters
// by exactly one pixel. vram_rd_address_o follows the counters, not the
// outputs.

module vram_display_reader #(
    parameter int          ACTIVE_COLUMNS = 640,
    parameter int          ACTIVE_ROWS    = 480,
    parameter int          ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int          DATA_WIDTH     = 1,
    parameter int          H_FRONT        = 16,
    parameter int          H_SYNC         = 96,
    parameter int          H_BACK         = 48,
    parameter int          V_FRONT        = 10,
    parameter int          V_SYNC         = 2,
    parameter int          V_BACK         = 33,
    parameter logic [11:0] SAND_COLOR     = 12'hFC0,
    parameter logic [11:0] BG_COLOR       = 12'h000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pixel_tick_i,
    input  logic [DATA_WIDTH-1:0] vram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] vram_rd_address_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic [11:0]           rgb_o,
    output logic                  video_on_o,
    output logic                  vblank_o,
    output logic                  frame_start_o
);

    localparam int H_TOTAL = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACTIVE   = HW'(ACTIVE_COLUMNS);
    localparam logic [VW-1:0] V_ACTIVE   = VW'(ACTIVE_ROWS);
    localparam logic [HW-1:0] HS_FIRST   = HW'(ACTIVE_COLUMNS + H_FRONT);
    localparam logic [HW-1:0] HS_LAST    = HW'(ACTIVE_COLUMNS + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(ACTIVE_ROWS + V_FRONT);
    localparam logic [VW-1:0] VS_LAST    = VW'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);

    // Scan position and address
    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Registered outputs
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;
    logic        video_on_q, video_on_d;
    logic        vblank_q, vblank_d;
    logic        frame_start_q, frame_start_d;

    logic active;
    logic frame_wrap;

    assign active = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        addr_d     = addr_q;
        frame_wrap = 1'b0;

        if (pixel_tick_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end

            // The address counts active pixels only. It therefore rests on
            // the first pixel of the next line through horizontal blanking.
            // After the last visible pixel it rests one past the end until
            // the frame wraps.
            if (frame_wrap) begin
                addr_d = '0;
            end else if (active) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        video_on_d    = video_on_q;
        vblank_d      = vblank_q;
        // The pulse occupies only the clk after the wrapping tick.
        frame_start_d = pixel_tick_i && frame_wrap;

        if (pixel_tick_i) begin
            hsync_d    = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
            vsync_d    = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
            video_on_d = active;
            vblank_d   = (v_q >= V_ACTIVE);
            if (active) begin
                rgb_d = vram_rd_data_i[0] ? SAND_COLOR : BG_COLOR;
            end else begin
                rgb_d = 12'h000;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_q           <= '0;
            v_q           <= '0;
            addr_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 12'h000;
            video_on_q    <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            addr_q        <= addr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            video_on_q    <= video_on_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vram_rd_address_o = addr_q;
    assign hsync_o           = hsync_q;
    assign vsync_o           = vsync_q;
    assign rgb_o             = rgb_q;
    assign video_on_o        = video_on_q;
    assign vblank_o          = vblank_q;
    assign frame_start_o     = frame_start_q;

endmodule

// File: tb/tb_vram_display_reader.sv
// Testbench for vram_display_reader.
// A reduced raster (20x12 active, 32x19 total) keeps whole frames short.
// Expected outputs come from a raster model written with plain arithmetic.
// The model pushes one expected word per tick into exp_q, and the sample
// after the tick pops it. Per-frame totals are also checked between
// consecutive frame_start_o pulses.

module tb_vram_display_reader;

  localparam int AC = 20;
  localparam int AR = 12;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = AC + HF + HS + HB;
  localparam int VT = AR + VF + VS + VB;
  localparam int AW = $clog2(AC * AR);
  localparam int EW = AW + 17;
  localparam logic [11:0] SAND = 12'hFC0;
  localparam logic [11:0] BG   = 12'h00F;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          hs;
    logic          vs;
    logic          von;
    logic          vbl;
    logic          fs;
    logic [11:0]   rgb;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          pixel_tick_i = 1'b0;
  logic [0:0]    vram_rd_data_i = 1'b0;
  logic [AW-1:0] vram_rd_address_o;
  logic          hsync_o, vsync_o, video_on_o, vblank_o, frame_start_o;
  logic [11:0]   rgb_o;

  always #5 clk_i = ~clk_i;

  vram_display_reader #(
    .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR), .ADDR_WIDTH(AW), .DATA_WIDTH(1),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SAND_COLOR(SAND), .BG_COLOR(BG)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .pixel_tick_i(pixel_tick_i),
    .vram_rd_data_i(vram_rd_data_i),
    .vram_rd_address_o(vram_rd_address_o),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .rgb_o(rgb_o),
    .video_on_o(video_on_o),
    .vblank_o(vblank_o),
    .frame_start_o(frame_start_o)
  );

  // VRAM model: one clk read latency
  logic mem [0:(1<<AW)-1];
  always @(posedge clk_i) vram_rd_data_i <= mem[vram_rd_address_o];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  logic [EW-1:0] exp_q[$];
  exp_t cur_exp;
  int mh, mv;

  // Raster index of the first not-yet-displayed active pixel.
  function automatic logic [AW-1:0] model_addr(input int h, input int v);
    int a;
    if (v >= AR) a = AC * AR;
    else a = v * AC + ((h < AC) ? h : AC);
    return AW'(a);
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    exp_q.delete();
    cur_exp = '{addr: '0, hs: 1'b1, vs: 1'b1, von: 1'b0, vbl: 1'b0, fs: 1'b0, rgb: 12'h000};
  endtask

  task automatic model_tick();
    exp_t e;
    bit act;
    act   = (mh < AC) && (mv < AR);
    e.hs  = !(mh >= AC + HF && mh < AC + HF + HS);
    e.vs  = !(mv >= AR + VF && mv < AR + VF + VS);
    e.von = act;
    e.vbl = (mv >= AR);
    e.rgb = act ? (mem[mv * AC + mh] ? SAND : BG) : 12'h000;
    e.fs  = (mh == HT - 1) && (mv == VT - 1);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    e.addr = model_addr(mh, mv);
    exp_q.push_back(EW'(e));
  endtask

  task automatic compare(input exp_t e);
    check("addr", 32'(vram_rd_address_o), 32'(e.addr));
    check("hsync", 32'(hsync_o), 32'(e.hs));
    check("vsync", 32'(vsync_o), 32'(e.vs));
    check("video_on", 32'(video_on_o), 32'(e.von));
    check("vblank", 32'(vblank_o), 32'(e.vbl));
    check("frame_start", 32'(frame_start_o), 32'(e.fs));
    check("rgb", 32'(rgb_o), 32'(e.rgb));
  endtask

  // Per-frame statistics, gathered from observed outputs
  int  win_ticks, hs_low, vs_low, vbl_cnt, von_cnt, sand_cnt, sand_pos, pulses;
  bit  have_pulse, sand_en;

  task automatic stats_reset();
    win_ticks = 0; hs_low = 0; vs_low = 0; vbl_cnt = 0; von_cnt = 0;
    sand_cnt = 0; sand_pos = -1;
  endtask

  task automatic stats_update();
    win_ticks++;
    if (!hsync_o) hs_low++;
    if (!vsync_o) vs_low++;
    if (vblank_o) vbl_cnt++;
    if (video_on_o) von_cnt++;
    if (rgb_o == SAND) begin
      sand_cnt++;
      if (sand_pos < 0) sand_pos = win_ticks;
    end
    if (frame_start_o) begin
      pulses++;
      if (have_pulse) begin
        check("frame_len", 32'(win_ticks), 32'(HT * VT));
        check("hsync_low_total", 32'(hs_low), 32'(HS * VT));
        check("vsync_low_total", 32'(vs_low), 32'(VS * HT));
        check("vblank_total", 32'(vbl_cnt), 32'((VT - AR) * HT));
        check("video_on_total", 32'(von_cnt), 32'(AC * AR));
        if (sand_en) begin
          check("sand_count", 32'(sand_cnt), 32'd1);
          check("sand_pos", 32'(sand_pos), 32'(HT + 1));
        end
      end
      have_pulse = 1'b1;
      stats_reset();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles, input bit tick_during);
    reset_i = 1'b1;
    pixel_tick_i = tick_during;
    @(posedge clk_i); #1;
    pixel_tick_i = 1'b0;
    model_reset();
    compare(cur_exp);
    repeat (cycles - 1) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    pulses = 0;
    have_pulse = 1'b0;
    stats_reset();
  endtask

  // gap >= 2 keeps at least one idle clk between ticks
  task automatic do_tick(input int gap);
    exp_t e;
    repeat (gap - 1) begin
      @(posedge clk_i); #1;
      e = cur_exp;
      e.fs = 1'b0;
      compare(e);
    end
    pixel_tick_i = 1'b1;
    model_tick();
    @(posedge clk_i); #1;
    pixel_tick_i = 1'b0;
    if (exp_q.size() == 0) begin
      check("exp_queue", 32'd0, 32'd1);
    end else begin
      e = exp_t'(exp_q.pop_front());
      cur_exp = e;
      compare(e);
      stats_update();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 1'($urandom_range(0, 1));
    mem[0] = 1'b1;
    sand_en = 1'b0;
    pulses = 0;
    have_pulse = 1'b0;
    stats_reset();
    model_reset();

    do_reset(3, 1'b0);
    for (int i = 0; i < 10; i++) do_tick(4);
    for (int i = 0; i < 2 * HT + 5; i++) do_tick($urandom_range(2, 5));
    // Long hold mid-line: 100 idle clks before the next tick
    do_tick(101);
    // Mid-line reset, with a tick during reset that must be ignored
    do_reset(2, 1'b1);

    for (int i = 0; i < 2 * HT * VT + 5; i++) do_tick($urandom_range(2, 4));
    check("pulses_random_vram", 32'(pulses), 32'd2);

    // Single lit cell at the first pixel of line 1
    for (int i = 0; i < (1 << AW); i++) mem[i] = 1'b0;
    mem[AC] = 1'b1;
    sand_en = 1'b1;
    do_reset(2, 1'b0);
    for (int i = 0; i < 2 * HT * VT + 5; i++) do_tick($urandom_range(2, 3));
    check("pulses_single_cell", 32'(pulses), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_display_reader.md
VRAM_DISPLAY_READER -- requirements
Module: vram_display_reader

Interface
REQ-001 SHALL have parameter ACTIVE_COLUMNS, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), meaning VRAM address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 1, meaning VRAM word width; only 1 is supported.
REQ-005 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48, V_FRONT 10, V_SYNC 2, V_BACK 33, meaning porch and sync widths in pixels or lines.
REQ-006 SHALL have parameter SAND_COLOR, default 12'hFC0, and parameter BG_COLOR, default 12'h000, meaning the RGB444 colours for cell values 1 and 0.
REQ-007 clk_i  input  1  system clock; one clock domain only.
REQ-008 reset_i  input  1  reset, synchronous and active-high.
REQ-009 pixel_tick_i  input  1  pixel enable, one clk wide, never asserted on two consecutive clk cycles.
REQ-010 vram_rd_data_i  input  DATA_WIDTH  VRAM read data, valid one clk after the address.
REQ-011 vram_rd_address_o  output  ADDR_WIDTH  VRAM read address.
REQ-012 hsync_o  output  1  horizontal sync, active low.
REQ-013 vsync_o  output  1  vertical sync, active low.
REQ-014 rgb_o  output  12  pixel colour.
REQ-015 video_on_o  output  1  high while rgb_o shows an active pixel.
REQ-016 vblank_o  output  1  high while the displayed line is at or beyond ACTIVE_ROWS; tells the writer that VRAM copies are safe.
REQ-017 frame_start_o  output  1  one-clk pulse at the start of each frame.

Function
REQ-018 SHALL define H_TOTAL = ACTIVE_COLUMNS+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = ACTIVE_ROWS+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 SHALL keep h_count and v_count registers that change only on clk edges where pixel_tick_i=1; all state SHALL hold when pixel_tick_i=0.
REQ-020 On a tick, h_count SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_count SHALL increment.
REQ-021 When h_count=H_TOTAL-1 and v_count=V_TOTAL-1, a tick SHALL wrap both counters to 0.
REQ-022 SHALL keep an address register that presents v_count*ACTIVE_COLUMNS+h_count while (h_count,v_count) is active, built by incrementing rather than multiplying.
REQ-023 On a tick in the active region, the address register SHALL increment by 1.
REQ-024 Outside the active region, the address register SHALL hold.
REQ-025 On the frame wrap of REQ-021, the address register SHALL load 0.
REQ-026 After the last active pixel (639,479), the address register SHALL hold 307200 until the frame wrap.
REQ-027 vram_rd_address_o SHALL be the address register directly.
REQ-028 Output stage: on each tick, the output registers SHALL capture from the pre-tick counters, giving one pixel of latency between counters and outputs.
REQ-029 On a tick, hsync_o SHALL load 0 iff h_count is in [656,751].
REQ-030 On a tick, vsync_o SHALL load 0 iff v_count is in [490,491].
REQ-031 On a tick, video_on_o SHALL load 1 iff h_count<ACTIVE_COLUMNS and v_count<ACTIVE_ROWS.
REQ-032 On a tick, vblank_o SHALL load 1 iff v_count>=ACTIVE_ROWS.
REQ-033 On a tick in the active region, rgb_o SHALL load SAND_COLOR if vram_rd_data_i=1, else BG_COLOR.
REQ-034 On a tick outside the active region, rgb_o SHALL load 12'h000.
REQ-035 frame_start_o SHALL be 1 for exactly the one clk following the tick that performs the frame wrap, and 0 otherwise.
REQ-036 The block SHALL never write VRAM and SHALL issue one read address per pixel.

Reset
REQ-037 While reset_i=1 at a clk edge, h_count, v_count and the address register SHALL be set to 0, and reset SHALL override pixel_tick_i.
REQ-038 While reset_i=1 at a clk edge, the outputs SHALL be set to hsync_o=1, vsync_o=1, rgb_o=0, video_on_o=0, vblank_o=0, frame_start_o=0.
REQ-039 Reset asserted mid-frame SHALL take effect at the next clk edge, and after release scanning SHALL restart at (0,0) with no frame_start_o pulse until the first wrap.

Verification
REQ-040 Reset release, VRAM returns 1 at address 0, tick every 4 clk -> vram_rd_address_o=0, and after the first tick rgb_o=12'hFC0 and video_on_o=1.
REQ-041 Tick through one line -> hsync_o low on exactly 96 consecutive ticks, starting with the capture of h=656.
REQ-042 Tick through one frame -> vsync_o low for 2 lines (1600 ticks), and vblank_o high for 45 lines.
REQ-043 Run 2 frames -> frame_start_o pulses are exactly 420000 ticks apart, each one clk wide.
REQ-044 VRAM model returns (addr==640) -> the single SAND_COLOR pixel appears at line 1, column 0, and the address stays 307200 during vblank.
REQ-045 Hold pixel_tick_i=0 for 100 clk mid-line -> all outputs and the address are unchanged, and assert reset mid-line -> defaults from REQ-038 apply on the next clk.
